// File: rtl/apb_pkg.sv
// Shared constants and FSM state type for the APB register slave.
package apb_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 4;
  localparam logic [IDX_W-1:0] SUM_IDX = 4'd15;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;
endpackage

// File: rtl/apb_regfile.sv
// Word register storage with one write port and one combinational read port;
// the top index reads back the sum of words 0 and 1 instead of its own storage.
module apb_regfile
  import apb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] regs_reg [DEPTH];
  logic [DATA_W-1:0] sum;

  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (wr_en) begin
      regs_reg[wr_idx] <= wr_data;
    end
  end

  // Carry out of the add is intentionally dropped.
  assign sum     = regs_reg[0] + regs_reg[1];
  assign rd_data = (rd_idx == SUM_IDX) ? sum : regs_reg[rd_idx];

endmodule

// File: rtl/apb_reg_slave.sv
// APB slave with programmable wait states in front of a small register file.
// state_reg records the phase just completed, so the access cycle is recognised
// combinationally and pready can rise in the very first access cycle.
module apb_reg_slave
  import apb_pkg::*;
#(
  parameter int WAIT_STATES = 2,
  parameter int DEPTH       = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              pwrite,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam logic [2:0] WAIT_CNT = 3'(WAIT_STATES);

  apb_state_e        state_reg, state_next;
  logic [2:0]        cnt_reg, cnt_next;
  logic              access_cycle;
  logic              addr_err;
  logic              access_err;
  logic              wr_en;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_data;

  assign idx        = paddr[5:2];
  assign addr_err   = (paddr[1:0] != 2'b00) || (paddr[ADDR_W-1:6] != '0);
  assign access_err = addr_err || (pwrite && (idx == SUM_IDX));

  // penable only counts once a setup phase has been seen.
  assign access_cycle = !preset && psel && penable && (state_reg != IDLE);
  assign pready       = access_cycle && (cnt_reg == WAIT_CNT);
  assign wr_en        = pready && pwrite && !access_err;
  assign pslverr      = pready && access_err;
  assign prdata       = (pready && !pwrite && !access_err) ? rd_data : '0;

  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    unique case (state_reg)
      IDLE: begin
        if (psel && !penable) state_next = SETUP;
      end
      SETUP, ACCESS: begin
        if (!psel) begin
          state_next = IDLE;
        end else if (!penable) begin
          state_next = SETUP;
        end else if (pready) begin
          state_next = IDLE;
        end else begin
          state_next = ACCESS;
          cnt_next   = cnt_reg + 3'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  apb_regfile #(
    .DEPTH(DEPTH)
  ) u_regfile (
    .pclk   (pclk),
    .preset (preset),
    .wr_en  (wr_en),
    .wr_idx (idx),
    .wr_data(pwdata),
    .rd_idx (idx),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_apb_reg_slave.sv
// Scoreboard bench: two slaves (2 wait states and 0 wait states) on one shared bus,
// each selected in turn; expected responses are queued at issue and popped on pready.
module tb_apb_reg_slave;

  logic        pclk = 1'b0;
  logic        preset, psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic        en0, en2;
  logic        psel0, psel2;
  logic [31:0] prdata0, prdata2;
  logic        pready0, pready2, pslverr0, pslverr2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t q2[$];
  exp_t q0[$];
  exp_t e2, e0;
  int   tests  = 0;
  int   errors = 0;
  bit   mon_on = 1'b0;

  always #5 pclk = ~pclk;

  assign psel2 = psel & en2;
  assign psel0 = psel & en0;

  apb_reg_slave #(.WAIT_STATES(2), .DEPTH(16)) dut (
    .pclk(pclk), .preset(preset), .psel(psel2), .penable(penable),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata2), .pready(pready2), .pslverr(pslverr2)
  );

  apb_reg_slave #(.WAIT_STATES(0), .DEPTH(16)) dut_ws0 (
    .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor for the 2-wait-state slave.
  always @(negedge pclk) begin
    if (mon_on) begin
      if (pready2 === 1'b1) begin
        if (q2.size() == 0) begin
          tests++;
          errors++;
          $display("FAIL ws2_unexpected_pready: got pready=1 expected 0 (paddr %h)", paddr);
        end else begin
          e2 = q2.pop_front();
          chk($sformatf("ws2_prdata@%h", e2.addr), prdata2, e2.rd);
          chk($sformatf("ws2_pslverr@%h", e2.addr), 32'(pslverr2), 32'(e2.err));
        end
      end else begin
        chk("ws2_pready_low", 32'(pready2), 32'd0);
        chk("ws2_idle_prdata", prdata2, 32'd0);
        chk("ws2_idle_pslverr", 32'(pslverr2), 32'd0);
      end
    end
  end

  // Monitor for the 0-wait-state slave.
  always @(negedge pclk) begin
    if (mon_on) begin
      if (pready0 === 1'b1) begin
        if (q0.size() == 0) begin
          tests++;
          errors++;
          $display("FAIL ws0_unexpected_pready: got pready=1 expected 0 (paddr %h)", paddr);
        end else begin
          e0 = q0.pop_front();
          chk($sformatf("ws0_prdata@%h", e0.addr), prdata0, e0.rd);
          chk($sformatf("ws0_pslverr@%h", e0.addr), 32'(pslverr0), 32'(e0.err));
        end
      end else begin
        chk("ws0_pready_low", 32'(pready0), 32'd0);
        chk("ws0_idle_prdata", prdata0, 32'd0);
        chk("ws0_idle_pslverr", 32'(pslverr0), 32'd0);
      end
    end
  end

  // One full transfer: setup, then access until the selected slave raises pready.
  task automatic xfer(input logic w, input logic [31:0] addr, input logic [31:0] data,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_waits);
    exp_t e;
    int   waits;
    e.addr = addr;
    e.rd   = exp_rd;
    e.err  = exp_err;
    if (en0) q0.push_back(e);
    else     q2.push_back(e);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = w;
    paddr   = addr;
    pwdata  = data;
    @(posedge pclk);
    #1 penable = 1'b1;
    waits = 0;
    forever begin
      @(negedge pclk);
      if ((en0 ? pready0 : pready2) === 1'b1) break;
      waits++;
      if (waits > 20) begin
        tests++;
        errors++;
        $display("FAIL timeout@%h: got no pready after %0d cycles expected %0d", addr, waits, exp_waits);
        psel = 1'b0;
        break;
      end
    end
    chk($sformatf("wait_cycles@%h", addr), 32'(waits), 32'(exp_waits));
    @(posedge pclk);
    #1;
  endtask

  task automatic idle(input int n);
    psel    = 1'b0;
    penable = 1'b0;
    repeat (n) @(posedge pclk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    preset  = 1'b1;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    en0     = 1'b0;
    en2     = 1'b1;
    @(posedge pclk);
    #1 mon_on = 1'b1;
    @(negedge pclk);
    chk("reset_prdata", prdata2, 32'd0);
    chk("reset_pready", 32'(pready2), 32'd0);
    chk("reset_pslverr", 32'(pslverr2), 32'd0);
    @(posedge pclk);
    #1 preset = 1'b0;

    // Setup issued in the first cycle out of reset.
    xfer(1'b1, 32'h04, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    xfer(1'b0, 32'h04, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    // Sum register wraps modulo 2^32.
    xfer(1'b1, 32'h00, 32'hFFFFFFFF, 32'h0, 1'b0, 2);
    xfer(1'b1, 32'h04, 32'h00000002, 32'h0, 1'b0, 2);
    xfer(1'b0, 32'h3C, 32'h0, 32'h00000001, 1'b0, 2);
    xfer(1'b0, 32'h00, 32'h0, 32'hFFFFFFFF, 1'b0, 2);
    // Error cases: write to sum index, out-of-range and misaligned addresses.
    xfer(1'b1, 32'h3C, 32'h12345678, 32'h0, 1'b1, 2);
    xfer(1'b1, 32'h40, 32'hCAFEF00D, 32'h0, 1'b1, 2);
    xfer(1'b0, 32'h02, 32'h0, 32'h0, 1'b1, 2);
    xfer(1'b1, 32'h02, 32'h00000077, 32'h0, 1'b1, 2);
    xfer(1'b0, 32'h40, 32'h0, 32'h0, 1'b1, 2);
    xfer(1'b0, 32'h3C, 32'h0, 32'h00000001, 1'b0, 2);
    xfer(1'b0, 32'h00, 32'h0, 32'hFFFFFFFF, 1'b0, 2);
    idle(2);

    // psel dropped in the second access cycle: abort, no write.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'hA5A5A5A5;
    @(posedge pclk);
    #1 penable = 1'b1;
    @(posedge pclk);
    #1 psel = 1'b0; penable = 1'b0;
    idle(3);
    xfer(1'b0, 32'h08, 32'h0, 32'h0, 1'b0, 2);
    idle(1);

    // penable without a setup phase is ignored.
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h55555555;
    repeat (4) @(posedge pclk);
    #1;
    idle(1);
    xfer(1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 2);
    idle(1);

    // Reset asserted in the access cycle that would have completed the write.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'hBADC0DE5;
    @(posedge pclk);
    #1 penable = 1'b1;
    repeat (2) @(posedge pclk);
    #1 preset = 1'b1;
    @(negedge pclk);
    chk("midreset_prdata", prdata2, 32'd0);
    chk("midreset_pready", 32'(pready2), 32'd0);
    chk("midreset_pslverr", 32'(pslverr2), 32'd0);
    @(posedge pclk);
    #1 psel = 1'b0; penable = 1'b0;
    @(posedge pclk);
    #1 preset = 1'b0;
    xfer(1'b0, 32'h0C, 32'h0, 32'h0, 1'b0, 2);
    xfer(1'b0, 32'h00, 32'h0, 32'h0, 1'b0, 2);
    xfer(1'b0, 32'h04, 32'h0, 32'h0, 1'b0, 2);
    idle(2);

    // Zero-wait-state slave: back-to-back transfers, two cycles each.
    en2 = 1'b0;
    en0 = 1'b1;
    xfer(1'b1, 32'h00, 32'h11111111, 32'h0, 1'b0, 0);
    xfer(1'b1, 32'h04, 32'h22222222, 32'h0, 1'b0, 0);
    xfer(1'b1, 32'h08, 32'h33333333, 32'h0, 1'b0, 0);
    xfer(1'b1, 32'h0C, 32'h44444444, 32'h0, 1'b0, 0);
    xfer(1'b0, 32'h00, 32'h0, 32'h11111111, 1'b0, 0);
    xfer(1'b0, 32'h04, 32'h0, 32'h22222222, 1'b0, 0);
    xfer(1'b0, 32'h08, 32'h0, 32'h33333333, 1'b0, 0);
    xfer(1'b0, 32'h0C, 32'h0, 32'h44444444, 1'b0, 0);
    xfer(1'b0, 32'h3C, 32'h0, 32'h33333333, 1'b0, 0);
    xfer(1'b1, 32'h3C, 32'h99999999, 32'h0, 1'b1, 0);
    xfer(1'b0, 32'h3C, 32'h0, 32'h33333333, 1'b0, 0);
    idle(3);

    chk("ws2_queue_drained", 32'(q2.size()), 32'd0);
    chk("ws0_queue_drained", 32'(q0.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/apb_reg_slave.md
APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 Parameter WAIT_STATES, default 2, number of pready-low cycles inserted in each access phase (range 0..7).
REQ-002 Parameter DEPTH, default 16, number of 32-bit word registers.
REQ-003 pclk  input  1  the block's single clock; all state updates on its rising edge.
REQ-004 preset  input  1  reset, synchronous and active-high.
REQ-005 psel  input  1  APB select from master.
REQ-006 penable  input  1  APB access-phase strobe.
REQ-007 paddr  input  32  byte address.
REQ-008 pwrite  input  1  1 = write, 0 = read.
REQ-009 pwdata  input  32  write data.
REQ-010 prdata  output  32  read data, valid only while pready is 1.
REQ-011 pready  output  1  transfer-complete strobe.
REQ-012 pslverr  output  1  error response, valid only while pready is 1.

Function
REQ-013 FSM states SHALL be IDLE, SETUP and ACCESS; IDLE->SETUP on psel=1 with penable=0; SETUP->ACCESS on psel=1 with penable=1; ACCESS->IDLE after the pready cycle, or ->SETUP if psel=1 and penable=0 in the following cycle.
REQ-014 A wait counter SHALL clear on entry to ACCESS; pready SHALL be 1 in the ACCESS cycle where the counter equals WAIT_STATES, and 0 in all other cycles.
REQ-015 With WAIT_STATES=0, pready SHALL be 1 in the first ACCESS cycle.
REQ-016 Register index SHALL be paddr[5:2].
REQ-017 An access SHALL be erroneous if paddr[1:0]!=0 or paddr[31:6]!=0.
REQ-018 A write SHALL be erroneous if it targets index 15.
REQ-019 Index 15 SHALL read the SUM of reg[0] and reg[1], modulo 2^32, with the carry discarded.
REQ-020 A non-erroneous write SHALL update reg[index] with pwdata at the rising edge where psel, penable and pready are all 1.
REQ-021 Erroneous writes SHALL update nothing.
REQ-022 During the pready cycle, prdata SHALL carry reg[index] (or SUM) for a non-erroneous read, and 0 for writes and errors.
REQ-023 Outside the pready cycle, prdata SHALL be 0.
REQ-024 pslverr SHALL be 1 only in the pready cycle of an erroneous access.
REQ-025 penable=1 without a preceding SETUP cycle SHALL be ignored: state stays IDLE, no pready, no write.
REQ-026 If psel drops during ACCESS before pready, the transfer SHALL be aborted with no write, the counter cleared, and the FSM returned to IDLE.
REQ-027 A read of index 0, 1 or 15 in the same cycle as a write commit to reg[0] or reg[1] SHALL return the pre-write value.
REQ-028 Back-to-back transfers (a SETUP cycle immediately after the pready cycle) SHALL be supported with no idle cycle.

Reset
REQ-029 While preset=1, all registers SHALL be cleared to 0, and prdata, pready and pslverr SHALL be 0.
REQ-030 While preset=1, the counter SHALL be 0 and the FSM SHALL be in IDLE.
REQ-031 A reset asserted mid-transfer SHALL abort the transfer with no write committed.
REQ-032 The first transfer SHALL be accepted on the cycle after preset deasserts.

Structure
REQ-033 Package apb_pkg SHALL hold the constants ADDR_W=32, DATA_W=32 and SUM_IDX=15, plus the FSM state enum.
REQ-034 Storage and SUM logic SHALL live in one sub-module, apb_regfile, which has one write port and one combinational read port.
REQ-035 The FSM, wait counter and error decode SHALL live in apb_reg_slave.

Verification
REQ-036 Write 0xDEADBEEF to 0x04, then read 0x04: read returns 0xDEADBEEF; pready is low for exactly 2 ACCESS cycles before it goes high; pslverr=0.
REQ-037 Write 0xFFFFFFFF to 0x00 and 0x00000002 to 0x04, then read 0x3C: read returns 0x00000001.
REQ-038 Write 0x12345678 to 0x3C, then access 0x40 and 0x02: each of these 3 accesses completes with pslverr=1, and a subsequent read of 0x3C is unchanged.
REQ-039 Drop psel in the second ACCESS cycle of a write of 0xA5A5A5A5 to 0x08: no pready is issued, and a later read of 0x08 returns 0.
REQ-040 Assert preset during the ACCESS phase of a write to 0x0C: no commit occurs, all outputs are 0, and a read of 0x0C after release returns 0.
REQ-041 Run with WAIT_STATES=0 and issue 4 back-to-back writes followed by reads: each transfer takes exactly 2 cycles and the data matches.
